serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor and the sequential successor of the team's combinational full adder. It consumes two WIDTH-bit operands plus a carry-in and processes DIGIT bits per clock, least-significant slice first, holding the inter-slice carry in a register. A start/busy/done handshake frames each operation. It targets datapaths where one narrow adder cell is time-shared instead of building a full-width ripple chain.

---
 rtl/serial_adder.sv | 139 +++++++++++++
 tb/tb_serial_adder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes DIGIT bits per clock, LSB slice first,
// with the inter-slice carry held in a register and a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    generate
        if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   carry_chain;
    logic [DIGIT-1:0] slice_sum;
    logic [WIDTH-1:0] slice_ext;
    logic             slice_co;
    logic             slice_msb_cin;

    // One DIGIT-wide ripple cell, shared across all slices of the operation.
    always_comb begin
        carry_chain    = '0;
        slice_sum      = '0;
        carry_chain[0] = c_q;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            slice_sum[i]       = a_q[i] ^ b_q[i] ^ carry_chain[i];
            carry_chain[i + 1] = (a_q[i] & b_q[i]) | (carry_chain[i] & (a_q[i] ^ b_q[i]));
        end
        slice_co      = carry_chain[DIGIT];
        slice_msb_cin = carry_chain[DIGIT-1];
        slice_ext     = WIDTH'(slice_sum);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + ~ci, so fold sub into B and the carry here.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = ci ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                r_d   = (r_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
                c_d   = slice_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(STEPS - 1)) begin
                    sum_d   = r_d;
                    co_d    = slice_co;
                    ovf_d   = slice_msb_cin ^ slice_co;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit
// instance checked against an integer-arithmetic reference model.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       s8_start, s8_sub, s8_ci;
    logic [7:0] s8_a, s8_b;
    logic       s8_busy, s8_done, s8_co, s8_ovf;
    logic [7:0] s8_sum;

    logic        w16_start, w16_sub, w16_ci;
    logic [15:0] w16_a, w16_b;
    logic        w16_busy, w16_done, w16_co, w16_ovf;
    logic [15:0] w16_sum;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_s8 (
        .clk(clk), .rst(rst), .start(s8_start), .sub(s8_sub),
        .a(s8_a), .b(s8_b), .ci(s8_ci),
        .busy(s8_busy), .done(s8_done), .sum(s8_sum), .co(s8_co), .ovf(s8_ovf)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16 (
        .clk(clk), .rst(rst), .start(w16_start), .sub(w16_sub),
        .a(w16_a), .b(w16_b), .ci(w16_ci),
        .busy(w16_busy), .done(w16_done), .sum(w16_sum), .co(w16_co), .ovf(w16_ovf)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns {ovf, co, sum[15:0]} computed with plain signed/unsigned integer math.
    function automatic logic [17:0] ref_model(int w, int ua, int ub, logic ci, logic sub);
        int modv, half, sa, sb, tot, sres, s;
        logic c, o;
        modv = 1 << w;
        half = modv / 2;
        sa   = (ua >= half) ? ua - modv : ua;
        sb   = (ub >= half) ? ub - modv : ub;
        if (!sub) begin
            tot  = ua + ub + int'(ci);
            c    = (tot >= modv);
            s    = tot % modv;
            sres = sa + sb + int'(ci);
        end else begin
            tot  = ua - ub - int'(ci);
            c    = (tot >= 0);
            s    = (tot + modv) % modv;
            sres = sa - sb - int'(ci);
        end
        o = (sres < -half) || (sres > half - 1);
        return {o, c, 16'(s)};
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub,
                       output int lat, output logic [9:0] res);
        s8_a = a; s8_b = b; s8_ci = ci; s8_sub = sub; s8_start = 1'b1;
        tick;
        s8_start = 1'b0;
        s8_a = 8'($urandom); s8_b = 8'($urandom); s8_ci = 1'($urandom); s8_sub = 1'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (s8_done === 1'b1) begin
                lat = n;
                break;
            end
        end
        res = {s8_ovf, s8_co, s8_sum};
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub,
                        output int lat, output logic [17:0] res);
        w16_a = a; w16_b = b; w16_ci = ci; w16_sub = sub; w16_start = 1'b1;
        tick;
        w16_start = 1'b0;
        w16_a = 16'($urandom); w16_b = 16'($urandom);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (w16_done === 1'b1) begin
                lat = n;
                break;
            end
        end
        res = {w16_ovf, w16_co, w16_sum};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s8_start = 1'b0; s8_sub = 1'b0; s8_ci = 1'b0; s8_a = '0; s8_b = '0;
        w16_start = 1'b0; w16_sub = 1'b0; w16_ci = 1'b0; w16_a = '0; w16_b = '0;
        tick;
        tick;
        checks++;
        if ({s8_busy, s8_done, s8_co, s8_ovf, s8_sum} !== 12'h000) begin
            errors++;
            $display("FAIL reset_s8: got %h expected 000", {s8_busy, s8_done, s8_co, s8_ovf, s8_sum});
        end
        checks++;
        if ({w16_busy, w16_done, w16_co, w16_ovf, w16_sum} !== 20'h00000) begin
            errors++;
            $display("FAIL reset_w16: got %h expected 00000", {w16_busy, w16_done, w16_co, w16_ovf, w16_sum});
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic_add;
        s8_a = 8'hA5; s8_b = 8'h3C; s8_ci = 1'b0; s8_sub = 1'b0; s8_start = 1'b1;
        tick;
        s8_start = 1'b0;
        s8_a = 8'h00; s8_b = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({s8_busy, s8_done, s8_sum} !== {1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL basic_busy_hold[%0d]: got %b expected 1_0_00000000", i, {s8_busy, s8_done, s8_sum});
            end
            tick;
        end
        checks++;
        if ({s8_busy, s8_done, s8_sum, s8_co, s8_ovf} !== {1'b0, 1'b1, 8'hE1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_done: got busy=%b done=%b sum=%h co=%b ovf=%b expected 0 1 e1 0 0",
                     s8_busy, s8_done, s8_sum, s8_co, s8_ovf);
        end
        tick;
        checks++;
        if ({s8_busy, s8_done, s8_sum} !== {1'b0, 1'b0, 8'hE1}) begin
            errors++;
            $display("FAIL basic_after: got busy=%b done=%b sum=%h expected 0 0 e1", s8_busy, s8_done, s8_sum);
        end
    endtask

    task automatic test_wrap_sub;
        logic [7:0] va [6] = '{8'hFF, 8'h7F, 8'hFF, 8'h05, 8'h80, 8'h10};
        logic [7:0] vb [6] = '{8'h01, 8'h01, 8'hFF, 8'h07, 8'h01, 8'h0F};
        logic       vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [9:0] ve [6] = '{{2'b01, 8'h00}, {2'b10, 8'h80}, {2'b01, 8'hFF},
                               {2'b00, 8'hFE}, {2'b11, 8'h7F}, {2'b01, 8'h00}};
        int lat;
        logic [9:0] res;
        for (int i = 0; i < 6; i++) begin
            op8(va[i], vb[i], vc[i], vs[i], lat, res);
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL wrap_sub_latency[%0d]: got %0d expected 8", i, lat);
            end
            checks++;
            if (res !== ve[i]) begin
                errors++;
                $display("FAIL wrap_sub_result[%0d]: got ovf,co,sum=%h expected %h", i, res, ve[i]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        s8_a = 8'h12; s8_b = 8'h34; s8_ci = 1'b0; s8_sub = 1'b0; s8_start = 1'b1;
        tick;
        s8_start = 1'b0;
        tick;
        tick;
        s8_a = 8'h99; s8_b = 8'h77; s8_ci = 1'b1; s8_sub = 1'b1; s8_start = 1'b1;
        tick;
        s8_start = 1'b0;
        lat = -1;
        for (int n = 4; n <= 40; n++) begin
            tick;
            if (s8_done === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL ignore_latency: got %0d expected 8", lat);
        end
        checks++;
        if ({s8_ovf, s8_co, s8_sum} !== {2'b00, 8'h46}) begin
            errors++;
            $display("FAIL ignore_result: got %h expected 046", {s8_ovf, s8_co, s8_sum});
        end
        for (int n = 0; n < 10; n++) begin
            tick;
            checks++;
            if ({s8_busy, s8_done} !== 2'b00) begin
                errors++;
                $display("FAIL ignore_not_queued[%0d]: got busy,done=%b expected 00", n, {s8_busy, s8_done});
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] expv;
        for (int t = 0; t < 36; t++) begin
            s8_a = 8'($urandom); s8_b = 8'($urandom);
            s8_ci = 1'($urandom); s8_sub = 1'($urandom);
            s8_start = 1'b1;
            if (t % 9 == 0) expv = ref_model(8, int'(s8_a), int'(s8_b), s8_ci, s8_sub);
            tick;
            checks++;
            if (t % 9 == 8) begin
                if ({s8_busy, s8_done, s8_ovf, s8_co, s8_sum} !== {2'b01, expv[17:16], expv[7:0]}) begin
                    errors++;
                    $display("FAIL b2b_done[%0d]: got busy,done,ovf,co,sum=%h expected %h",
                             t, {s8_busy, s8_done, s8_ovf, s8_co, s8_sum}, {2'b01, expv[17:16], expv[7:0]});
                end
            end else if ({s8_busy, s8_done} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_busy[%0d]: got busy,done=%b expected 10", t, {s8_busy, s8_done});
            end
        end
        s8_start = 1'b0;
        tick;
    endtask

    task automatic test_reset_midop;
        int lat;
        logic [9:0] res;
        logic [17:0] expv;
        op8(8'hA5, 8'h3C, 1'b0, 1'b0, lat, res);
        checks++;
        if (res !== 10'h0E1) begin
            errors++;
            $display("FAIL rstmid_pre: got %h expected 0e1", res);
        end
        s8_a = 8'h11; s8_b = 8'h22; s8_ci = 1'b1; s8_sub = 1'b0; s8_start = 1'b1;
        tick;
        s8_start = 1'b0;
        for (int n = 0; n < 4; n++) tick;
        rst = 1'b1; s8_start = 1'b1;
        tick;
        rst = 1'b0; s8_start = 1'b0;
        checks++;
        if ({s8_busy, s8_done, s8_co, s8_ovf, s8_sum} !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_clear: got %h expected 000", {s8_busy, s8_done, s8_co, s8_ovf, s8_sum});
        end
        for (int n = 0; n < 12; n++) begin
            tick;
            checks++;
            if ({s8_busy, s8_done, s8_sum} !== 10'h000) begin
                errors++;
                $display("FAIL rstmid_quiet[%0d]: got busy,done,sum=%h expected 000", n, {s8_busy, s8_done, s8_sum});
            end
        end
        s8_a = 8'($urandom); s8_b = 8'($urandom); s8_ci = 1'($urandom); s8_sub = 1'($urandom);
        expv = ref_model(8, int'(s8_a), int'(s8_b), s8_ci, s8_sub);
        op8(s8_a, s8_b, s8_ci, s8_sub, lat, res);
        checks++;
        if (lat !== 8 || res !== {expv[17:16], expv[7:0]}) begin
            errors++;
            $display("FAIL rstmid_fresh: got lat=%0d res=%h expected 8 %h", lat, res, {expv[17:16], expv[7:0]});
        end
    endtask

    task automatic test_wide_digit;
        int lat;
        logic [17:0] res, expv;
        logic [15:0] ra, rb;
        logic rc, rs;
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, res);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL wide_latency: got %0d expected 4", lat);
        end
        checks++;
        if (res !== {2'b01, 16'h0000}) begin
            errors++;
            $display("FAIL wide_wrap: got %h expected 10000", res);
        end
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            expv = ref_model(16, int'(ra), int'(rb), rc, rs);
            op16(ra, rb, rc, rs, lat, res);
            checks++;
            if (lat !== 4 || res !== expv) begin
                errors++;
                $display("FAIL wide_rand[%0d]: a=%h b=%h ci=%b sub=%b got lat=%0d res=%h expected 4 %h",
                         i, ra, rb, rc, rs, lat, res, expv);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic_add;
        test_wrap_sub;
        test_ignore_start;
        test_back_to_back;
        test_reset_midop;
        test_wide_digit;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
